// File: rtl/main_memory_responder.sv
// Backing-store responder for cache line refills (reads) and evictions (writes).
// One request at a time; each line moves as a LINE_WORDS-beat burst after LATENCY idle cycles.
module main_memory_responder #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LINE_WORDS      = 8,
    parameter int MEM_DEPTH_WORDS = 4096,
    parameter int LATENCY         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_done,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy
);

    localparam int LWB   = $clog2(LINE_WORDS);
    localparam int MAW   = $clog2(MEM_DEPTH_WORDS);
    localparam int LAW   = MAW - LWB;
    localparam int LAT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [2:0] {IDLE, WAIT, RD_BURST, WR_BURST, WR_RESP} state_t;

    typedef struct packed {
        logic           write;
        logic [LAW-1:0] line;
    } req_t;

    state_t                 state_q, state_d;
    req_t                   req_q;
    logic [LAT_W-1:0]       lat_q;
    logic [LWB-1:0]         beat_q;
    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH_WORDS];

    logic           req_hs, wr_hs, rd_hs, rd_fetch, last_beat;
    logic [MAW-1:0] mem_addr;
    logic           unused_addr_bits;

    assign req_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == WR_BURST);
    assign wr_done   = (state_q == WR_RESP);
    assign busy      = (state_q != IDLE);

    assign req_hs    = req_valid && req_ready;
    assign wr_hs     = wr_valid && wr_ready;
    assign rd_hs     = rd_valid && rd_ready;
    assign last_beat = (beat_q == LWB'(LINE_WORDS - 1));
    assign mem_addr  = {req_q.line, beat_q};

    // Output register is refilled when empty or when its beat is being taken,
    // so a stalled beat holds and back-to-back beats stream without bubbles.
    assign rd_fetch = (state_q == RD_BURST) && (!rd_valid || (rd_ready && !rd_last));

    // Word-offset and above-depth address bits are dropped so addresses wrap.
    assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:MAW+2], req_addr[LWB+1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    if (LATENCY == 0) state_d = req_write ? WR_BURST : RD_BURST;
                    else              state_d = WAIT;
                end
            end
            WAIT:     if (lat_q <= LAT_W'(1)) state_d = req_q.write ? WR_BURST : RD_BURST;
            RD_BURST: if (rd_hs && rd_last) state_d = IDLE;
            WR_BURST: if (wr_hs && last_beat) state_d = WR_RESP;
            WR_RESP:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q    <= '0;
            lat_q    <= '0;
            beat_q   <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (req_hs) begin
                req_q.write <= req_write;
                req_q.line  <= req_addr[MAW+1:LWB+2];
                lat_q       <= LAT_W'(LATENCY);
                beat_q      <= '0;
            end
            if (state_q == WAIT) lat_q <= lat_q - LAT_W'(1);
            if (rd_fetch) begin
                rd_data  <= mem[mem_addr];
                rd_valid <= 1'b1;
                rd_last  <= last_beat;
                beat_q   <= beat_q + LWB'(1);
            end else if (rd_hs) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
            if (wr_hs) beat_q <= beat_q + LWB'(1);
        end
    end

    // Backing array has no reset: contents survive reset and abandoned bursts.
    always_ff @(posedge clk) begin
        if (wr_hs) mem[mem_addr] <= wr_data;
    end

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: table-driven line transfers, random traffic against
// a word-array model, plus hand sequences for reset-mid-burst and a zero-latency instance.
module tb_main_memory_responder;

    localparam int LAT = 4;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_write, wr_valid, wr_ready, wr_done;
    logic        rd_valid, rd_ready, rd_last, busy;
    logic [31:0] req_addr, wr_data, rd_data;

    logic        z_req_valid, z_req_ready, z_req_write, z_wr_valid, z_wr_ready, z_wr_done;
    logic        z_rd_valid, z_rd_ready, z_rd_last, z_busy;
    logic [31:0] z_req_addr, z_wr_data, z_rd_data;

    main_memory_responder #(.LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_done(wr_done), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_last(rd_last), .busy(busy));

    main_memory_responder #(.LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_write(z_req_write), .req_addr(z_req_addr), .wr_valid(z_wr_valid),
        .wr_ready(z_wr_ready), .wr_data(z_wr_data), .wr_done(z_wr_done),
        .rd_valid(z_rd_valid), .rd_ready(z_rd_ready), .rd_data(z_rd_data),
        .rd_last(z_rd_last), .busy(z_busy));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int passed = 0;
    int total  = 0;

    logic [31:0] ref_mem [int];
    bit          gap_pat [5] = '{1, 0, 1, 1, 0};

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] base;  // write data / expected read data is base + word
        int          mode;  // 0 steady, 1 fixed gap/stall pattern
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int line_word(input logic [31:0] a);
        return ((int'(a >> 2) % 4096) / 8) * 8;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data [8], input int mode);
        int  k, n, cyc, drops, dones;
        bit  v;
        req_valid = 1; req_write = 1; req_addr = addr;
        k = 0;
        while (!req_ready && k < 200) begin tick(); k++; end
        check("wr_req_ready", req_ready, 1);
        tick();
        req_valid = 0; req_write = 0;
        k = 0;
        while (!wr_ready && k < 200) begin
            wr_valid = 1; wr_data = 32'hDEAD_0000 + k;
            tick(); k++;
        end
        check("wr_first_ready_latency", k, LAT);
        n = 0; cyc = 0; drops = 0; dones = 0;
        while (n < 8 && cyc < 200) begin
            if (!wr_ready) drops++;
            if (wr_done) dones++;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? gap_pat[cyc % 5] : ($urandom_range(0, 3) != 0);
            wr_valid = v;
            wr_data  = v ? data[n] : 32'hBAD0_0000 + cyc;
            if (v && wr_ready) n++;
            tick(); cyc++;
        end
        wr_valid = 0;
        check("wr_beats", n, 8);
        check("wr_ready_held", drops, 0);
        check("wr_done_early", dones, 0);
        check("wr_done_pulse", wr_done, 1);
        check("wr_resp_req_ready", req_ready, 0);
        tick();
        check("wr_done_clear", wr_done, 0);
        check("wr_idle_req_ready", req_ready, 1);
        for (int i = 0; i < 8; i++) ref_mem[line_word(addr) + i] = data[i];
    endtask

    task automatic do_read(input logic [31:0] addr, input int mode, input int abort_after,
                           output logic [31:0] got [8]);
        int          k, n, cyc;
        bit          rr, prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        for (int i = 0; i < 8; i++) got[i] = 'x;
        req_valid = 1; req_write = 0; req_addr = addr;
        wr_valid = 1; wr_data = 32'hEEEE_0000;
        rd_ready = (mode == 0);
        k = 0;
        while (!req_ready && k < 200) begin tick(); k++; end
        check("rd_req_ready", req_ready, 1);
        tick();
        req_valid = 0;
        k = 0;
        while (!rd_valid && k < 200) begin tick(); k++; end
        check("rd_first_valid_latency", k, LAT + 1);
        n = 0; cyc = 0; prev_stall = 0; prev_data = 0; prev_last = 0;
        while (n < 8 && n < abort_after && cyc < 200) begin
            if (mode == 0) check("rd_no_gap", rd_valid, 1);
            if (prev_stall) begin
                check("rd_hold_data", rd_data, prev_data);
                check("rd_hold_last", rd_last, prev_last);
            end
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            rd_ready = rr;
            if (rd_valid && rr) begin
                got[n] = rd_data;
                check("rd_last_pos", rd_last, (n == 7));
                n++;
            end
            prev_stall = rd_valid && !rr;
            prev_data  = rd_data;
            prev_last  = rd_last;
            tick(); cyc++;
        end
        rd_ready = 0; wr_valid = 0;
        if (n == abort_after) return;
        check("rd_beats", n, 8);
        check("rd_valid_after_last", rd_valid, 0);
        check("rd_idle_req_ready", req_ready, 1);
    endtask

    logic [31:0] wdata [8];
    logic [31:0] got   [8];
    logic [31:0] wq    [$];
    logic [31:0] a2;
    int          n, lastpos, k;

    initial begin
        rst_n = 1; req_valid = 0; req_write = 0; req_addr = 0; wr_valid = 0; wr_data = 0;
        rd_ready = 0;
        z_req_valid = 0; z_req_write = 0; z_req_addr = 0; z_wr_valid = 0; z_wr_data = 0;
        z_rd_ready = 0;
        #2 rst_n = 0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_wr_done", wr_done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        tick();

        // zero-latency instance: write then read back one line
        z_req_valid = 1; z_req_write = 1; z_req_addr = 32'h40;
        check("z_wr_req_ready", z_req_ready, 1);
        tick();
        z_req_valid = 0;
        check("z_wr_ready_first", z_wr_ready, 1);
        n = 0; k = 0;
        while (n < 8 && k < 50) begin
            z_wr_valid = 1; z_wr_data = 32'h5A00 + n;
            if (z_wr_ready) n++;
            tick(); k++;
        end
        z_wr_valid = 0;
        check("z_wr_done", z_wr_done, 1);
        tick();
        z_req_valid = 1; z_req_write = 0; z_req_addr = 32'h40;
        check("z_rd_req_ready", z_req_ready, 1);
        tick();
        z_req_valid = 0;
        check("z_lat0_cycle0", z_rd_valid, 0);
        tick();
        check("z_lat0_cycle1", z_rd_valid, 1);
        z_rd_ready = 1; n = 0; lastpos = -1;
        for (int c = 0; c < 12; c++) begin
            if (z_rd_valid && z_rd_ready) begin
                check("z_rd_data", z_rd_data, 32'h5A00 + n);
                if (z_rd_last) lastpos = n;
                n++;
            end
            tick();
        end
        z_rd_ready = 0;
        check("z_rd_beats", n, 8);
        check("z_rd_last_pos", lastpos, 7);

        vecs[0] = '{1, 32'h0000_0100, 32'hA0, 0};
        vecs[1] = '{0, 32'h0000_0100, 32'hA0, 0};
        vecs[2] = '{0, 32'h0000_0100, 32'hA0, 1};
        vecs[3] = '{1, 32'h0000_0200, 32'hB0, 1};
        vecs[4] = '{0, 32'h0000_0200, 32'hB0, 0};
        vecs[5] = '{1, 32'h0000_4020, 32'hC0, 0};
        vecs[6] = '{0, 32'h0000_0020, 32'hC0, 0};
        vecs[7] = '{1, 32'h0000_0300, 32'hD0, 0};
        vecs[8] = '{0, 32'h0000_031C, 32'hD0, 1};
        vecs[9] = '{0, 32'h0000_4020, 32'hC0, 0};
        foreach (vecs[v]) begin
            if (vecs[v].wr) begin
                for (int i = 0; i < 8; i++) wdata[i] = vecs[v].base + i;
                do_write(vecs[v].addr, wdata, vecs[v].mode);
            end else begin
                do_read(vecs[v].addr, vecs[v].mode, 8, got);
                for (int i = 0; i < 8; i++)
                    check($sformatf("vec%0d_word%0d", v, i), got[i], vecs[v].base + i);
            end
        end

        // reset in the middle of a read burst, then a clean re-read
        do_read(32'h0000_0100, 0, 3, got);
        check("pre_rst_rd_valid", rd_valid, 1);
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 0;
        #1;
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_rd_last", rd_last, 0);
        check("mid_rst_rd_data", rd_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_req_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1;
        do_read(32'h0000_0100, 0, 8, got);
        for (int i = 0; i < 8; i++) check("post_rst_word", got[i], 32'hA0 + i);

        // random traffic against the word-array model
        wq.push_back(32'h0000_0100);
        wq.push_back(32'h0000_0200);
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                a2 = $urandom;
                for (int i = 0; i < 8; i++) wdata[i] = $urandom;
                do_write(a2, wdata, 2);
                wq.push_back(a2);
            end else begin
                a2 = wq[$urandom_range(0, wq.size() - 1)];
                a2 = (a2 & 32'h0000_3FE0) | ($urandom & 32'hFFFF_C000) | ($urandom & 32'h1F);
                do_read(a2, 2, 8, got);
                for (int i = 0; i < 8; i++)
                    check("rand_rd_word", got[i], ref_mem[line_word(a2) + i]);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/main_memory_responder.md
# main_memory_responder

Memory-side responder for the processor's instruction-cache and data-cache line transfers. It accepts line-refill (read) and line-eviction (write) requests from a cache controller through a valid/ready request channel. It returns or absorbs a full cache line as a burst of words after a programmable access latency. It models the backing store behind the cache level of the pipelined RISC-V core and gives the cache controllers a cycle-accurate partner for integration and verification.

## Interface
- ADDR_WIDTH, 32, request byte-address width
- DATA_WIDTH, 32, beat width in bits
- LINE_WORDS, 8, words per cache line; power of two, at least 2
- MEM_DEPTH_WORDS, 4096, backing-array depth in words; power of two
- LATENCY, 4, idle cycles between request acceptance and the first data beat; 0 allowed
- CLK  in  1  sole clock; all state changes on the rising edge
- RST_N  in  1  asynchronous active-low reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  responder can accept a request
- REQ_WRITE  in  1  1 = line write (eviction), 0 = line read (refill)
- REQ_ADDR  in  ADDR_WIDTH  line byte address; low log2(LINE_WORDS)+2 bits ignored
- WR_VALID  in  1  write beat present
- WR_READY  out  1  responder accepts a write beat
- WR_DATA  in  DATA_WIDTH  write beat data
- WR_DONE  out  1  one-cycle pulse: line write complete
- RD_VALID  out  1  read beat present
- RD_READY  in  1  cache accepts the read beat
- RD_DATA  out  DATA_WIDTH  read beat data
- RD_LAST  out  1  marks the final beat of a read burst
- BUSY  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, WAIT, RD_BURST, WR_BURST, WR_RESP.
- IDLE: REQ_READY=1. On REQ_VALID&&REQ_READY:
  - Latch the line base word index = REQ_ADDR[ADDR_WIDTH-1:2] with the low log2(LINE_WORDS) bits cleared, taken modulo MEM_DEPTH_WORDS. Upper address bits are silently dropped, so addresses wrap.
  - Latch REQ_WRITE.
  - Load the latency counter with LATENCY.
  - Go to WAIT. If LATENCY=0, go directly to RD_BURST or WR_BURST.
- WAIT: decrement the counter each cycle. When it reaches 1, go to RD_BURST or WR_BURST on the next edge.
- RD_BURST:
  - Beats are issued in order word 0 to LINE_WORDS-1 of the line; no critical-word-first.
  - RD_DATA is registered.
  - While RD_VALID && !RD_READY, RD_DATA and RD_LAST hold stable.
  - The beat counter advances only on a handshake.
  - RD_LAST=1 exactly on beat LINE_WORDS-1. A handshake on that beat returns the FSM to IDLE.
- WR_BURST:
  - WR_READY=1 throughout.
  - Each WR_VALID&&WR_READY writes WR_DATA to base+beat and advances the beat counter.
  - After LINE_WORDS handshakes, go to WR_RESP.
- WR_RESP: WR_DONE=1 for exactly one cycle, then IDLE.
- Only one request is outstanding at a time; REQ_READY=0 outside IDLE.
- WR_VALID in any state other than WR_BURST is ignored and writes nothing.
- Reset:
  - Asynchronous; forces IDLE and clears all counters and output registers.
  - The backing array is not cleared and keeps its contents across reset.
  - A burst interrupted by reset is abandoned. Words already written stay written.

## Timing
- Reset values:
  - REQ_READY=1 (IDLE).
  - WR_READY=0, WR_DONE=0, RD_VALID=0, RD_LAST=0, RD_DATA=0, BUSY=0.
- Read: request accepted at edge T. The first RD_VALID is high in the cycle after edge T+LATENCY+1.
- Read with RD_READY held high: LINE_WORDS consecutive beats. REQ_READY is high again in the cycle after the RD_LAST handshake.
- Write with WR_VALID held high:
  - WR_READY is high for LINE_WORDS cycles, starting in the cycle after edge T+LATENCY.
  - WR_DONE follows the final write handshake by one cycle.
  - REQ_READY returns one cycle after WR_DONE.
- Read-after-write to the same line returns the newly written data. The write is committed before WR_DONE.
- Back-to-back requests need no dead cycle beyond the IDLE acceptance cycle.

## Test plan
- Reset, then a write of line 0x100 with data 0xA0..0xA7, then a read of 0x100 with RD_READY=1, LATENCY=4 -> WR_DONE one pulse. Read beats 0xA0..0xA7 arrive on 8 consecutive cycles, first beat 5 cycles after acceptance. RD_LAST only on 0xA7.
- Read with RD_READY toggled 1,0,0,1,... -> no beat lost or duplicated. RD_DATA and RD_LAST hold while stalled. Exactly 8 handshakes.
- Write with WR_VALID gaps (pattern 1,0,1,1,0,...) -> only handshaked beats are written; the read-back of line 0x200 matches the 8 handshaked words in order.
- Address wrap: write line at word index MEM_DEPTH_WORDS+8 (byte address (4096+8)*4 with defaults), read line at word index 8 -> identical data. REQ_ADDR low bits 0x1C -> same line as 0x00.
- LATENCY=0 instance: read accepted at edge T -> RD_VALID high in the cycle after edge T+1.
- RST_N pulsed low mid read burst (after beat 3) -> outputs return to reset values immediately and asynchronously. After reset release a new read of the same line returns the full correct line from beat 0.
